fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word-index `pc` into instruction memory, which answers combinationally with `inst_in`.
- Registers the fetched word into the IF/ID pipeline register for the decoder.
- Handles next-PC selection (sequential or redirect), pipeline stall, wrong-path flush, and a halt state for fetches beyond the end of memory.

---
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 106 ++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with PC, IF/ID register, redirect, stall, flush and halt
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_DEPTH = 65,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] inst_in,
  output logic [31:0] pc,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, pcp1_q, pcp1_d, cnt_q, cnt_d;
  logic valid_q, valid_d, halted_q, halted_d;
  logic in_range;
  assign in_range = pc_q < 32'(MEM_DEPTH);
  // next-state: BOOT waits one cycle, RUN prioritises redirect over stall over sequential fetch, HALT waits for a redirect
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pcp1_d   = pcp1_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (state_q == HALT) begin
      if (redirect_valid) begin
        pc_d     = redirect_pc;
        halted_d = 1'b0;
        state_d  = RUN;
      end
    end else if (redirect_valid) begin
      pc_d    = redirect_pc;
      inst_d  = NOP_WORD;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (in_range) begin
        inst_d  = inst_in;
        pcp1_d  = pc_q + 32'd1;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd1;
        cnt_d   = cnt_q + 32'd1;
      end else begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
        state_d  = HALT;
      end
    end
  end
  // state registers with synchronous reset overriding every other update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      inst_q   <= NOP_WORD;
      pcp1_q   <= 32'd0;
      cnt_q    <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pcp1_q   <= pcp1_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end
  assign pc            = pc_q;
  assign ifid_inst     = inst_q;
  assign ifid_pc_plus1 = pcp1_q;
  assign ifid_valid    = valid_q;
  assign halted        = halted_q;
  assign fetch_count   = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed checks of fetch_unit against hand-computed expectations
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0, inst_in;
  logic [31:0] pc, ifid_inst, ifid_pc_plus1, fetch_count;
  logic ifid_valid, halted;
  logic [31:0] mem [0:79];
  int total = 0, bad = 0;

  typedef struct {
    logic rst, st, rv;
    logic [31:0] rpc, pc, inst, pcp1, cnt;
    logic val, hlt;
  } vec_t;
  vec_t tv[$];

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_in(inst_in), .pc(pc), .ifid_inst(ifid_inst),
    .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always_comb inst_in = (pc < 32'd80) ? mem[pc[6:0]] : 32'hdead_beef;

  function automatic vec_t mk(logic rst, logic st, logic rv, logic [31:0] rpc, logic [31:0] epc,
                              logic [31:0] einst, logic [31:0] epcp1, logic eval, logic ehlt,
                              logic [31:0] ecnt);
    vec_t v;
    v.rst = rst; v.st = st; v.rv = rv; v.rpc = rpc; v.pc = epc; v.inst = einst;
    v.pcp1 = epcp1; v.val = eval; v.hlt = ehlt; v.cnt = ecnt;
    return v;
  endfunction

  task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(vec_t v);
    @(negedge clk);
    reset = v.rst; stall = v.st; redirect_valid = v.rv; redirect_pc = v.rpc;
    @(posedge clk);
    #1;
    cmp("pc", pc, v.pc);
    cmp("ifid_inst", ifid_inst, v.inst);
    cmp("ifid_pc_plus1", ifid_pc_plus1, v.pcp1);
    cmp("ifid_valid", {31'd0, ifid_valid}, {31'd0, v.val});
    cmp("halted", {31'd0, halted}, {31'd0, v.hlt});
    cmp("fetch_count", fetch_count, v.cnt);
  endtask

  initial begin
    for (int i = 0; i < 80; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h2010_0001; mem[1] = 32'h0010_2020; mem[2] = 32'h0c00_000a; mem[10] = 32'h3088_0001;
    //                rst st rv rpc   pc    inst           pcp1   val hlt cnt
    tv.push_back(mk(1, 0, 0, 0,  0,  32'h0,          0,  0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,  0,  32'h0,          0,  0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,  1,  32'h2010_0001,  1,  1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0,  2,  32'h0010_2020,  2,  1, 0, 2));
    tv.push_back(mk(0, 0, 0, 0,  3,  32'h0c00_000a,  3,  1, 0, 3));
    tv.push_back(mk(0, 0, 1, 10, 10, 32'h0,          3,  0, 0, 3));
    tv.push_back(mk(0, 0, 0, 0,  11, 32'h3088_0001,  11, 1, 0, 4));
    tv.push_back(mk(0, 0, 1, 4,  4,  32'h0,          11, 0, 0, 4));
    tv.push_back(mk(0, 0, 0, 0,  5,  32'h1000_0004,  5,  1, 0, 5));
    tv.push_back(mk(0, 1, 0, 0,  5,  32'h1000_0004,  5,  1, 0, 5));
    tv.push_back(mk(0, 1, 0, 0,  5,  32'h1000_0004,  5,  1, 0, 5));
    tv.push_back(mk(0, 1, 0, 0,  5,  32'h1000_0004,  5,  1, 0, 5));
    tv.push_back(mk(0, 1, 1, 15, 15, 32'h0,          5,  0, 0, 5));
    tv.push_back(mk(0, 0, 0, 0,  16, 32'h1000_000f,  16, 1, 0, 6));
    tv.push_back(mk(0, 0, 1, 63, 63, 32'h0,          16, 0, 0, 6));
    tv.push_back(mk(0, 0, 0, 0,  64, 32'h1000_003f,  64, 1, 0, 7));
    tv.push_back(mk(0, 0, 0, 0,  65, 32'h1000_0040,  65, 1, 0, 8));
    tv.push_back(mk(0, 0, 0, 0,  65, 32'h1000_0040,  65, 0, 1, 8));
    foreach (tv[i]) step(tv[i]);
    // halted: pc and count frozen, stall ignored
    for (int i = 0; i < 10; i++)
      step(mk(0, i[0], 0, 0, 65, 32'h1000_0040, 65, 0, 1, 8));
    // leave HALT by redirect to 0, then run to pc=7
    step(mk(0, 0, 1, 0, 0, 32'h1000_0040, 65, 0, 0, 8));
    step(mk(0, 0, 0, 0, 1, 32'h2010_0001, 1, 1, 0, 9));
    step(mk(0, 0, 0, 0, 2, 32'h0010_2020, 2, 1, 0, 10));
    step(mk(0, 0, 0, 0, 3, 32'h0c00_000a, 3, 1, 0, 11));
    for (int i = 4; i <= 7; i++)
      step(mk(0, 0, 0, 0, i, 32'h1000_0000 | (i - 1), i, 1, 0, 32'(i + 8)));
    // reset mid-run while stalled, BOOT repeats before first capture
    step(mk(1, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 1, 32'h2010_0001, 1, 1, 0, 1));
    // out-of-range redirect halts on the next cycle without capture
    step(mk(0, 0, 1, 70, 70, 32'h0, 1, 0, 0, 1));
    step(mk(0, 0, 0, 0, 70, 32'h0, 1, 0, 1, 1));
    step(mk(0, 0, 1, 70, 70, 32'h0, 1, 0, 0, 1));
    step(mk(0, 0, 0, 0, 70, 32'h0, 1, 0, 1, 1));
    // reset from HALT
    step(mk(1, 0, 1, 9, 0, 32'h0, 0, 0, 0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
